swim_byte_tx: RTL and testbench

SWIM_BYTE_TX -- requirements
Module: swim_byte_tx

---
 rtl/swim_byte_tx.sv | 195 +++++++++++++++++++
 tb/tb_swim_byte_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/swim_byte_tx.sv
// swim_byte_tx
//   Sends one byte on the STM8 SWIM single-wire line and collects the
//   target's ack/nack.
//   Frame: start bit 0, the eight data bits MSB first, then even parity.
//   Bit encoding: a 0 is a long low phase followed by a short released phase.
//   A 1 is a short low phase followed by a long released phase.
//   After the frame, the block waits for the target's ack pulse and samples
//   it halfway into a bit time. A short pulse reads as ack, a long pulse as nack.
//
// Ports
//   clk            single clock (48 MHz domain)
//   reset_n        asynchronous active-low reset
//   in_data[7:0]   byte to send
//   in_valid       in_data is valid
//   in_ready       byte is accepted this cycle (IDLE only)
//   swim_drive_low 1 pulls the open-drain line low, 0 releases it
//   swim_in        raw pad level (asynchronous)
//   res_valid      one-cycle pulse per completed frame
//   res_ack        target acked (1) / nacked (0); held until the next res_valid
//   res_timeout    no ack edge arrived; held until the next res_valid
//   busy           high in every state except IDLE
module swim_byte_tx #(
    parameter int SHORT_CYC   = 12,
    parameter int LONG_CYC    = 120,
    parameter int ACK_TIMEOUT = 4800
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       swim_drive_low,
    input  logic       swim_in,
    output logic       res_valid,
    output logic       res_ack,
    output logic       res_timeout,
    output logic       busy
);

    localparam int BIT_CYC  = SHORT_CYC + LONG_CYC;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int MAX_A    = (LONG_CYC > SHORT_CYC) ? LONG_CYC : SHORT_CYC;
    localparam int MAX_B    = (ACK_TIMEOUT > MAX_A) ? ACK_TIMEOUT : MAX_A;
    localparam int CNT_MAX  = (HALF_CYC > MAX_B) ? HALF_CYC : MAX_B;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SHORT_LAST   = CNT_W'(SHORT_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST    = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST    = CNT_W'(HALF_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_BIT_LOW    = 3'd1;
    localparam logic [2:0] S_BIT_HIGH   = 3'd2;
    localparam logic [2:0] S_ACK_WAIT   = 3'd3;
    localparam logic [2:0] S_ACK_SAMPLE = 3'd4;
    localparam logic [2:0] S_ACK_END    = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       frame_q, frame_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic             ack_smp_q, ack_smp_d;
    logic             res_valid_q, res_valid_d;
    logic             res_ack_q, res_ack_d;
    logic             res_timeout_q, res_timeout_d;
    logic             ready_en_q;
    logic             sync1_q, sync2_q, prev_q;
    logic             fall;

    // A falling edge on the synchronised line. It is only acted on in ACK_WAIT,
    // so glitches during the frame have no effect.
    assign fall = prev_q & ~sync2_q;

    // ready_en_q holds in_ready low until the first edge after reset.
    // Masking with res_valid_q makes the next byte acceptable only on the
    // cycle after the result pulse.
    assign in_ready       = ready_en_q && (state_q == S_IDLE) && !res_valid_q;
    assign busy           = (state_q != S_IDLE);
    assign swim_drive_low = (state_q == S_BIT_LOW);
    assign res_valid      = res_valid_q;
    assign res_ack        = res_ack_q;
    assign res_timeout    = res_timeout_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        frame_d       = frame_q;
        bit_idx_d     = bit_idx_q;
        ack_smp_d     = ack_smp_q;
        res_valid_d   = 1'b0;
        res_ack_d     = res_ack_q;
        res_timeout_d = res_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    frame_d   = {1'b0, in_data, ^in_data};
                    bit_idx_d = 4'd0;
                    cnt_d     = '0;
                    state_d   = S_BIT_LOW;
                end
            end
            S_BIT_LOW: begin
                // frame_q[9] is the bit currently on the wire.
                if (cnt_q == (frame_q[9] ? SHORT_LAST : LONG_LAST)) begin
                    cnt_d   = '0;
                    state_d = S_BIT_HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_BIT_HIGH: begin
                if (cnt_q == (frame_q[9] ? LONG_LAST : SHORT_LAST)) begin
                    cnt_d = '0;
                    if (bit_idx_q == 4'd9) begin
                        state_d = S_ACK_WAIT;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        frame_d   = {frame_q[8:0], 1'b0};
                        state_d   = S_BIT_LOW;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_ACK_WAIT: begin
                // An edge that lands on the timeout cycle still counts as an ack.
                if (fall) begin
                    cnt_d   = '0;
                    state_d = S_ACK_SAMPLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d         = '0;
                    state_d       = S_IDLE;
                    res_valid_d   = 1'b1;
                    res_ack_d     = 1'b0;
                    res_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_ACK_SAMPLE: begin
                // Half a bit time after the edge, a short pulse is already
                // released and a long pulse is still low.
                if (cnt_q == HALF_LAST) begin
                    ack_smp_d = sync2_q;
                    cnt_d     = '0;
                    state_d   = S_ACK_END;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_ACK_END: begin
                if (sync2_q) begin
                    state_d       = S_IDLE;
                    res_valid_d   = 1'b1;
                    res_ack_d     = ack_smp_q;
                    res_timeout_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            frame_q       <= '0;
            bit_idx_q     <= '0;
            ack_smp_q     <= 1'b0;
            res_valid_q   <= 1'b0;
            res_ack_q     <= 1'b0;
            res_timeout_q <= 1'b0;
            ready_en_q    <= 1'b0;
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            prev_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            frame_q       <= frame_d;
            bit_idx_q     <= bit_idx_d;
            ack_smp_q     <= ack_smp_d;
            res_valid_q   <= res_valid_d;
            res_ack_q     <= res_ack_d;
            res_timeout_q <= res_timeout_d;
            ready_en_q    <= 1'b1;
            sync1_q       <= swim_in;
            sync2_q       <= sync1_q;
            prev_q        <= sync2_q;
        end
    end

endmodule

// File: tb/tb_swim_byte_tx.sv
`timescale 1ns/1ps
module tb_swim_byte_tx;

    localparam int BITC   = 132;
    localparam int FRAME  = 1320;
    localparam int TMO    = 4800;
    localparam int ACK_AT = 1325;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       swim_drive_low;
    logic       swim_in;
    logic       res_valid;
    logic       res_ack;
    logic       res_timeout;
    logic       busy;

    always #5 clk = ~clk;

    swim_byte_tx #(.SHORT_CYC(12), .LONG_CYC(120), .ACK_TIMEOUT(4800)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .swim_drive_low(swim_drive_low), .swim_in(swim_in),
        .res_valid(res_valid), .res_ack(res_ack), .res_timeout(res_timeout), .busy(busy)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Hand-computed low-phase widths (120 = bit 0, 12 = bit 1), start bit first.
    int exp_a5[10] = '{120, 12, 120, 12, 120, 120, 12, 120, 12, 120};
    int exp_01[10] = '{120, 120, 120, 120, 120, 120, 120, 120, 12, 12};
    int exp_00[10] = '{120, 120, 120, 120, 120, 120, 120, 120, 120, 120};
    int exp_5a[10] = '{120, 120, 12, 120, 12, 12, 120, 12, 120, 120};

    // Capture results of one frame.
    int   lw[10];
    int   ls[10];
    int   nruns;
    int   rv_t;
    logic rv_ack, rv_to;
    logic saw_ready, saw_idle, saw_rv;

    // Handshake one byte, then watch the line from the first BIT_LOW cycle
    // (t=0) until res_valid while playing the target. Returns at the negedge
    // of the res_valid cycle.
    task automatic run_frame(input logic [7:0] b, input int glitch_at, input int ack_low,
                             input logic keep_valid, input logic [7:0] next_b);
        int   t;
        int   wt;
        logic prev;
        nruns = 0; rv_t = -1; rv_ack = 1'bx; rv_to = 1'bx;
        saw_ready = 1'b0; saw_idle = 1'b0; saw_rv = 1'b0;
        for (int i = 0; i < 10; i++) begin lw[i] = 0; ls[i] = -1; end
        in_data = b; in_valid = 1'b1; wt = 0;
        while (!in_ready && wt < 10000) begin @(negedge clk); wt++; end
        @(negedge clk);
        if (keep_valid) in_data = next_b; else in_valid = 1'b0;
        prev = 1'b0; t = 0;
        while (!saw_rv && t < FRAME + TMO + 200) begin
            if (swim_drive_low && !prev) begin
                if (nruns < 10) ls[nruns] = t;
                nruns++;
            end
            if (swim_drive_low && nruns >= 1 && nruns <= 10) lw[nruns-1]++;
            prev = swim_drive_low;
            if (in_ready) saw_ready = 1'b1;
            if (!busy && !res_valid) saw_idle = 1'b1;
            if (res_valid) begin
                saw_rv = 1'b1; rv_t = t; rv_ack = res_ack; rv_to = res_timeout;
            end
            if (glitch_at >= 0 && t >= glitch_at && t < glitch_at + 3) swim_in = 1'b0;
            else if (ack_low > 0 && t >= ACK_AT && t < ACK_AT + ack_low) swim_in = 1'b0;
            else swim_in = 1'b1;
            if (!saw_rv) begin @(negedge clk); t++; end
        end
        swim_in = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; swim_in = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else pass_cnt++;
        chk_cnt++; if (swim_drive_low !== 1'b0) $display("FAIL rst_drive: got %b want 0", swim_drive_low); else pass_cnt++;
        chk_cnt++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid: got %b want 0", res_valid); else pass_cnt++;
        chk_cnt++; if (res_ack !== 1'b0) $display("FAIL rst_res_ack: got %b want 0", res_ack); else pass_cnt++;
        chk_cnt++; if (res_timeout !== 1'b0) $display("FAIL rst_res_timeout: got %b want 0", res_timeout); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
        #2 reset_n = 1'b1;
        #1;
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_ready_before_edge: got %b want 0", in_ready); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_ready_first_edge: got %b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_ack_a5();
        run_frame(8'hA5, -1, 12, 1'b0, 8'h00);
        chk_cnt++; if (nruns !== 10) $display("FAIL a5_runs: got %0d want 10", nruns); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            chk_cnt++; if (lw[i] !== exp_a5[i]) $display("FAIL a5_width[%0d]: got %0d want %0d", i, lw[i], exp_a5[i]); else pass_cnt++;
            chk_cnt++; if (ls[i] !== i * BITC) $display("FAIL a5_start[%0d]: got %0d want %0d", i, ls[i], i * BITC); else pass_cnt++;
        end
        chk_cnt++; if (saw_ready !== 1'b0) $display("FAIL a5_ready_in_frame: got %b want 0", saw_ready); else pass_cnt++;
        chk_cnt++; if (saw_idle !== 1'b0) $display("FAIL a5_busy_drop: got %b want 0", saw_idle); else pass_cnt++;
        chk_cnt++; if (saw_rv !== 1'b1) $display("FAIL a5_res_valid: got %b want 1", saw_rv); else pass_cnt++;
        chk_cnt++; if (rv_ack !== 1'b1) $display("FAIL a5_res_ack: got %b want 1", rv_ack); else pass_cnt++;
        chk_cnt++; if (rv_to !== 1'b0) $display("FAIL a5_res_timeout: got %b want 0", rv_to); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (res_valid !== 1'b0) $display("FAIL a5_pulse_len: got %b want 0", res_valid); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL a5_ready_after: got %b want 1", in_ready); else pass_cnt++;
        repeat (5) @(negedge clk);
        chk_cnt++; if (res_ack !== 1'b1) $display("FAIL a5_ack_hold: got %b want 1", res_ack); else pass_cnt++;
    endtask

    task automatic test_nack_01();
        run_frame(8'h01, -1, 120, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            chk_cnt++; if (lw[i] !== exp_01[i]) $display("FAIL 01_width[%0d]: got %0d want %0d", i, lw[i], exp_01[i]); else pass_cnt++;
        end
        chk_cnt++; if (saw_rv !== 1'b1) $display("FAIL 01_res_valid: got %b want 1", saw_rv); else pass_cnt++;
        chk_cnt++; if (rv_ack !== 1'b0) $display("FAIL 01_res_ack: got %b want 0", rv_ack); else pass_cnt++;
        chk_cnt++; if (rv_to !== 1'b0) $display("FAIL 01_res_timeout: got %b want 0", rv_to); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_timeout_00();
        run_frame(8'h00, -1, 0, 1'b0, 8'h00);
        chk_cnt++; if (nruns !== 10) $display("FAIL 00_runs: got %0d want 10", nruns); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            chk_cnt++; if (lw[i] !== exp_00[i]) $display("FAIL 00_width[%0d]: got %0d want %0d", i, lw[i], exp_00[i]); else pass_cnt++;
        end
        chk_cnt++; if (rv_t !== FRAME + TMO) $display("FAIL 00_timeout_time: got %0d want %0d", rv_t, FRAME + TMO); else pass_cnt++;
        chk_cnt++; if (rv_to !== 1'b1) $display("FAIL 00_res_timeout: got %b want 1", rv_to); else pass_cnt++;
        chk_cnt++; if (rv_ack !== 1'b0) $display("FAIL 00_res_ack: got %b want 0", rv_ack); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_glitch();
        // Bit 1 of 0xA5 is a 1: released from t=144 to t=263.
        run_frame(8'hA5, 150, 12, 1'b0, 8'h00);
        chk_cnt++; if (nruns !== 10) $display("FAIL gl_runs: got %0d want 10", nruns); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            chk_cnt++; if (lw[i] !== exp_a5[i]) $display("FAIL gl_width[%0d]: got %0d want %0d", i, lw[i], exp_a5[i]); else pass_cnt++;
            chk_cnt++; if (ls[i] !== i * BITC) $display("FAIL gl_start[%0d]: got %0d want %0d", i, ls[i], i * BITC); else pass_cnt++;
        end
        chk_cnt++; if (rv_ack !== 1'b1) $display("FAIL gl_res_ack: got %b want 1", rv_ack); else pass_cnt++;
        chk_cnt++; if (rv_to !== 1'b0) $display("FAIL gl_res_timeout: got %b want 0", rv_to); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int t;
        run_frame(8'h5A, -1, 12, 1'b1, 8'hFF);
        for (int i = 0; i < 10; i++) begin
            chk_cnt++; if (lw[i] !== exp_5a[i]) $display("FAIL b2b_width[%0d]: got %0d want %0d", i, lw[i], exp_5a[i]); else pass_cnt++;
        end
        chk_cnt++; if (saw_ready !== 1'b0) $display("FAIL b2b_ready_in_frame: got %b want 0", saw_ready); else pass_cnt++;
        chk_cnt++; if (rv_ack !== 1'b1) $display("FAIL b2b_res_ack: got %b want 1", rv_ack); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_ready_at_rv: got %b want 0", in_ready); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_after_rv: got %b want 1", in_ready); else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        chk_cnt++; if (swim_drive_low !== 1'b1) $display("FAIL b2b_second_start: got %b want 1", swim_drive_low); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL b2b_second_busy: got %b want 1", busy); else pass_cnt++;
        // Second frame runs with the line held high and must time out.
        t = 0;
        while (!res_valid && t < FRAME + TMO + 200) begin @(negedge clk); t++; end
        chk_cnt++; if (t !== FRAME + TMO) $display("FAIL b2b_second_time: got %0d want %0d", t, FRAME + TMO); else pass_cnt++;
        chk_cnt++; if (res_timeout !== 1'b1) $display("FAIL b2b_second_timeout: got %b want 1", res_timeout); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int wt;
        in_data = 8'h00; in_valid = 1'b1; wt = 0;
        while (!in_ready && wt < 100) begin @(negedge clk); wt++; end
        @(negedge clk);
        in_valid = 1'b0;
        // Land inside the low phase of bit 4.
        repeat (4 * BITC + 20) @(negedge clk);
        chk_cnt++; if (swim_drive_low !== 1'b1) $display("FAIL rm_pre_drive: got %b want 1", swim_drive_low); else pass_cnt++;
        #2 reset_n = 1'b0;
        #1;
        chk_cnt++; if (swim_drive_low !== 1'b0) $display("FAIL rm_drive_release: got %b want 0", swim_drive_low); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL rm_in_ready: got %b want 0", in_ready); else pass_cnt++;
        chk_cnt++; if (res_timeout !== 1'b0) $display("FAIL rm_res_timeout: got %b want 0", res_timeout); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (res_valid !== 1'b0) $display("FAIL rm_res_valid: got %b want 0", res_valid); else pass_cnt++;
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rm_ready_after: got %b want 1", in_ready); else pass_cnt++;
        chk_cnt++; if (res_valid !== 1'b0) $display("FAIL rm_no_result: got %b want 0", res_valid); else pass_cnt++;
        chk_cnt++; if (swim_drive_low !== 1'b0) $display("FAIL rm_drive_after: got %b want 0", swim_drive_low); else pass_cnt++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ack_a5();
        test_nack_01();
        test_timeout_00();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
